pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline buffer; successor to the fixed single-register valid/allowin links between the IF/ID/EXE/MEM/WB stages.
- Generalises the link to a configurable bus width and a configurable depth (an elastic FIFO).
- Adds a synchronous flush, an exception-lock that blocks further intake after a faulting entry, and an occupancy output.
- Instantiated between any two stages, e.g. between the IF and ID stages with BUS_W=64 to decouple fetch from decode stalls.

Parameters:
- BUS_W, 64, width of the payload bus carried per entry.
- EXC_W, 6, width of the exception code carried alongside each entry.
- DEPTH, 2, number of entries; must be a power of two, range 1..16.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived, do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  drop all held entries and clear the exception lock (branch/jump/trap redirect).
- in_valid  input  1  upstream stage presents a valid entry.
- in_allowin  output  1  buffer accepts the entry this cycle.
- in_bus  input  BUS_W  upstream payload.
- in_exc  input  EXC_W  upstream exception code; 0 = none.
- out_valid  output  1  head entry valid toward downstream.
- out_allowin  input  1  downstream accepts the head entry this cycle.
- out_bus  output  BUS_W  head payload.
- out_exc  output  EXC_W  head exception code.
- count  output  CNT_W  number of stored entries (0..DEPTH).
- exc_locked  output  1  a nonzero-exception entry has been accepted since the last flush or reset.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr, rd_ptr, count and exc_locked clear to 0 immediately.
  - out_valid=0; out_bus and out_exc = 0.
  - Storage contents are don't-care but must not be observable.
- Handshakes:
  - push = in_valid & in_allowin.
  - pop = out_valid & out_allowin.
  - Both are evaluated in the same cycle; pointers wrap modulo DEPTH.
- in_allowin (combinational):
  - Equals !flush & !exc_locked & ((count<DEPTH) | pop).
  - When full, a simultaneous pop frees a slot, so push is allowed in the same cycle.
- out_valid:
  - Equals (count!=0) & !flush.
  - out_bus and out_exc come from the entry at rd_ptr.
  - When count==0, out_bus and out_exc are driven to 0.
- count update:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N (1 cycle), unless the bypass below is enabled.
- Exception lock:
  - On a push with in_exc!=0, exc_locked is set at that edge.
  - The faulting entry is stored and drains normally; entries already held ahead of it also drain.
  - No further pushes are accepted until flush.
- Flush (synchronous, highest priority):
  - During the flush cycle, in_allowin=0 and out_valid=0, so neither push nor pop occurs.
  - At the edge, pointers, count and exc_locked clear to 0.
  - A flush held for several cycles keeps the buffer empty.
- DEPTH=1: behaves as the classic stage register, with in_allowin = !valid | out_allowin.
- Reset asserted mid-transfer discards all entries; no partial entry survives.

Optional Feature:
- Macro: PIPE_STAGE_BUF_BYPASS_EN.
- Defined:
  - Bypass condition: count==0, in_valid=1, out_allowin=1, !flush and !exc_locked all hold.
  - Under that condition, out_valid=1, out_bus=in_bus and out_exc=in_exc combinationally.
  - The entry is consumed with 0-cycle latency; it is not stored and count stays 0.
  - A bypassed entry with in_exc!=0 still sets exc_locked.
- Undefined:
  - No combinational in-to-out path.
  - Minimum latency is 1 cycle, as described above.

Test Plan:
- Fill (DEPTH=4, BUS_W=64): push 0x1..0x5 with out_allowin=0 -> the first four are accepted, count=4 and in_allowin=0 on the fifth; then out_allowin=1 -> pops 0x1,0x2,0x3,0x4 in order.
- Full push+pop: count=4, in_valid=1 and out_allowin=1 for 3 cycles -> 3 pushes and 3 pops, count stays 4, order preserved across pointer wrap.
- Exception lock: push 0xA (exc=0), then 0xB (exc=6'h02), then 0xC -> 0xC is refused and exc_locked=1; 0xA then 0xB drain with out_exc=0 then 0x02; in_allowin stays 0 until flush.
- Flush: count=3 and flush=1 for one cycle -> out_valid=0 that cycle; count=0 and exc_locked=0 the next cycle; a push attempted during flush is not accepted.
- Reset mid-operation: count=2, drop rst_n asynchronously between edges -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
- Bypass (macro defined): empty buffer, in_valid=1, out_allowin=1, in_bus=0x55 -> same cycle out_valid=1, out_bus=0x55, count stays 0; with the macro undefined, 0x55 appears one cycle later.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//   Elastic buffer placed between two pipeline stages. It holds up to DEPTH
//   entries of {bus, exc} with valid/allowin handshakes on both sides.
//
//   It also provides:
//   - a synchronous flush, used for branch, jump or trap redirects;
//   - an exception lock that stops intake once a faulting entry is accepted;
//   - an occupancy count.
//
//   DEPTH=1 behaves like the classic stage register.
//
// Optional feature (macro PIPE_STAGE_BUF_BYPASS_EN):
//   When the macro is defined, an empty buffer whose downstream is ready
//   passes the incoming entry straight to the output in the same cycle.
//   The bypassed entry is not stored.
//   When the macro is undefined, there is no combinational in-to-out path.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        drop all entries, clear the exception lock
//   in_valid     upstream entry valid
//   in_allowin   buffer accepts the upstream entry this cycle
//   in_bus       upstream payload  [BUS_W]
//   in_exc       upstream exception code [EXC_W], 0 = none
//   out_valid    head entry valid toward downstream
//   out_allowin  downstream accepts the head entry this cycle
//   out_bus      head payload [BUS_W]
//   out_exc      head exception code [EXC_W]
//   count        stored entries, 0..DEPTH [CNT_W]
//   exc_locked   a faulting entry was accepted since the last flush/reset
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int BUS_W   = 64,
    parameter int EXC_W   = 6,
    parameter int DEPTH   = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_allowin,
    input  logic [BUS_W-1:0] in_bus,
    input  logic [EXC_W-1:0] in_exc,
    output logic             out_valid,
    input  logic             out_allowin,
    output logic [BUS_W-1:0] out_bus,
    output logic [EXC_W-1:0] out_exc,
    output logic [CNT_W-1:0] count,
    output logic             exc_locked
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BUS_W-1:0] bus_mem [DEPTH];
    logic [EXC_W-1:0] exc_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             exc_locked_q;

    logic has_entry;
    logic fifo_pop;
    logic push;
    logic bypass;
    logic store;

    // DEPTH is a power of two, so natural binary wrap is modulo DEPTH.
    // The single-entry case must stay at 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1)
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign has_entry = (count_q != '0);

    // A flush blocks both sides, so neither handshake fires in a flush cycle.
    assign fifo_pop   = has_entry & ~flush & out_allowin;
    assign in_allowin = ~flush & ~exc_locked_q
                        & ((count_q < CNT_W'(DEPTH)) | fifo_pop);
    assign push       = in_valid & in_allowin;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
    assign bypass = ~has_entry & in_valid & out_allowin & ~flush & ~exc_locked_q;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry is consumed at the output and never written.
    assign store = push & ~bypass;

    assign out_valid = (has_entry & ~flush) | bypass;

    always_comb begin
        out_bus = '0;
        out_exc = '0;
        if (has_entry) begin
            out_bus = bus_mem[rd_ptr];
            out_exc = exc_mem[rd_ptr];
        end else if (bypass) begin
            out_bus = in_bus;
            out_exc = in_exc;
        end
    end

    assign count      = count_q;
    assign exc_locked = exc_locked_q;

    // Storage: data only, no reset. Nothing can read a slot before it has
    // been written, because the output is forced to 0 when count==0.
    always_ff @(posedge clk) begin
        if (store) begin
            bus_mem[wr_ptr] <= in_bus;
            exc_mem[wr_ptr] <= in_exc;
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            exc_locked_q <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            exc_locked_q <= 1'b0;
        end else begin
            if (store)
                wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({store, fifo_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A faulting entry locks intake whether it is stored or bypassed.
            if (push && (in_exc != '0))
                exc_locked_q <= 1'b1;
        end
    end

endmodule
